oryx_exec_sequencer: RTL and testbench



---
 rtl/oryx_isa_pkg.sv | 44 ++++
 rtl/oryx_exec_sequencer_if.sv | 34 +++
 rtl/oryx_sat_counter.sv | 19 +
 rtl/oryx_exec_sequencer.sv | 105 ++++++++++
 tb/tb_oryx_exec_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/oryx_isa_pkg.sv
// Shared ISA constants and sequencer state encoding for the oryx execution core.
package oryx_isa_pkg;

    localparam logic [2:0] OPC_ARITH  = 3'd0;
    localparam logic [2:0] OPC_DATA   = 3'd1;
    localparam logic [2:0] OPC_BRANCH = 3'd2;
    localparam logic [2:0] OPC_JUMP   = 3'd3;
    localparam logic [2:0] OPC_CMP    = 3'd4;
    localparam logic [2:0] OPC_FLOAT  = 3'd5;
    localparam logic [2:0] OPC_LOGIC  = 3'd6;
    localparam logic [2:0] OPC_SHIFT  = 3'd7;

    localparam logic [1:0] F_MUL = 2'd3;
    localparam logic [1:0] F_LW  = 2'd0;
    localparam logic [1:0] F_SW  = 2'd1;
    localparam logic [1:0] F_LUI = 2'd2;
    localparam logic [1:0] F_SUB = 2'd3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_EXEC     = 3'd1;
    localparam logic [2:0] S_MUL_WAIT = 3'd2;
    localparam logic [2:0] S_FPU_WAIT = 3'd3;
    localparam logic [2:0] S_MEM_WAIT = 3'd4;
    localparam logic [2:0] S_COMMIT   = 3'd5;
    localparam logic [2:0] S_ERROR    = 3'd6;

    // First state after accepting an instruction, chosen from class and funct.
    function automatic logic [2:0] dispatch_state(input logic [2:0] cls, input logic [1:0] funct);
        if (cls == OPC_ARITH && funct == F_MUL)                   return S_MUL_WAIT;
        if (cls == OPC_FLOAT)                                      return S_FPU_WAIT;
        if (cls == OPC_DATA && (funct == F_LW || funct == F_SW))   return S_MEM_WAIT;
        return S_EXEC;
    endfunction

    function automatic logic writes_back(input logic [2:0] cls, input logic [1:0] funct);
        case (cls)
            OPC_ARITH:                              return funct != F_MUL;
            OPC_DATA:                               return funct != F_SW;
            OPC_CMP, OPC_LOGIC, OPC_SHIFT:          return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/oryx_exec_sequencer_if.sv
// Fetch, resource and retire signals of the execution sequencer bundled as one port.
interface oryx_exec_sequencer_if #(parameter int CNT_W = 16) ();
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic             mul_start;
    logic             mul_done;
    logic             fpu_start;
    logic [1:0]       fpu_op;
    logic             fpu_done;
    logic             mem_req;
    logic             mem_we;
    logic             mem_ack;
    logic             br_taken;
    logic             commit;
    logic             wb_en;
    logic             redirect;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  instr_valid, instr, mul_done, fpu_done, mem_ack, br_taken,
        output instr_ready, mul_start, fpu_start, fpu_op, mem_req, mem_we,
               commit, wb_en, redirect, busy, err, retired_cnt, stall_cnt
    );

    modport slave (
        output instr_valid, instr, mul_done, fpu_done, mem_ack, br_taken,
        input  instr_ready, mul_start, fpu_start, fpu_op, mem_req, mem_we,
               commit, wb_en, redirect, busy, err, retired_cnt, stall_cnt
    );
endinterface

// File: rtl/oryx_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module oryx_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    q <= '0;
        else if (clear)             q <= '0;
        else if (inc && q != '1)    q <= q + 1'b1;
    end

endmodule

// File: rtl/oryx_exec_sequencer.sv
// Issue/retire controller: one instruction in flight, sequences mul/fpu/stack memory, commits in order.
module oryx_exec_sequencer
    import oryx_isa_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    oryx_exec_sequencer_if.master  bus
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [2:0]        state, state_nxt;
    logic [4:0]        op_q;
    logic              br_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_wait, wait_done, handshake;
    logic              commit_w;
    logic [CNT_W-1:0]  retired_q, stall_q;

    wire [2:0] cls   = op_q[4:2];
    wire [1:0] funct = op_q[1:0];

    assign handshake = (state == S_IDLE) && bus.instr_valid;
    assign in_wait   = (state == S_MUL_WAIT) || (state == S_FPU_WAIT) || (state == S_MEM_WAIT);

    // Only the done/ack of the resource being waited on counts; the others are ignored.
    always_comb begin
        wait_done = 1'b0;
        case (state)
            S_MUL_WAIT: wait_done = bus.mul_done;
            S_FPU_WAIT: wait_done = bus.fpu_done;
            S_MEM_WAIT: wait_done = bus.mem_ack;
            default:    wait_done = 1'b0;
        endcase
    end

    // NOTE: next state defaults to the current state so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (bus.instr_valid) state_nxt = dispatch_state(bus.instr[31:29], bus.instr[28:27]);
            S_EXEC:     state_nxt = S_COMMIT;
            S_MUL_WAIT,
            S_FPU_WAIT,
            S_MEM_WAIT: begin
                if (wait_done)                                   state_nxt = S_COMMIT;
                else if (wait_cnt == WAIT_W'(TIMEOUT - 1))       state_nxt = S_ERROR;
            end
            S_COMMIT:   state_nxt = S_IDLE;
            S_ERROR:    state_nxt = S_ERROR;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            br_q     <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (handshake)         op_q <= bus.instr[31:27];
            if (state == S_EXEC)   br_q <= bus.br_taken;
            // Clears on any non-wait cycle, so it is zero on the first cycle of every wait.
            wait_cnt <= in_wait ? wait_cnt + 1'b1 : '0;
        end
    end

    assign commit_w        = (state == S_COMMIT);
    assign bus.instr_ready = (state == S_IDLE);
    assign bus.busy        = (state != S_IDLE);
    assign bus.err         = (state == S_ERROR);
    assign bus.mul_start   = (state == S_MUL_WAIT) && (wait_cnt == '0);
    assign bus.fpu_start   = (state == S_FPU_WAIT) && (wait_cnt == '0);
    assign bus.fpu_op      = funct;
    assign bus.mem_req     = (state == S_MEM_WAIT);
    assign bus.mem_we      = (state == S_MEM_WAIT) && (funct == F_SW);
    assign bus.commit      = commit_w;
    assign bus.wb_en       = commit_w && writes_back(cls, funct);
    assign bus.redirect    = commit_w && ((cls == OPC_JUMP) || (cls == OPC_BRANCH && br_q));

    oryx_sat_counter #(.W(CNT_W)) u_retired_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (commit_w),
        .q     (retired_q)
    );

    oryx_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (in_wait),
        .q     (stall_q)
    );

    assign bus.retired_cnt = retired_q;
    assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_oryx_exec_sequencer.sv
// Randomized self-checking bench for oryx_exec_sequencer against a transaction-level model.
module tb_oryx_exec_sequencer;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    oryx_exec_sequencer_if #(.CNT_W(CNT_W)) bus ();

    oryx_exec_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    int exp_ret   = 0;
    int exp_stall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.mul_done    = 1'b0;
        bus.fpu_done    = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.br_taken    = 1'b0;
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > CMAX) ? CMAX : a + b;
    endfunction

    // Ends at a negedge in IDLE with model counters zeroed.
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ret   = 0;
        exp_stall = 0;
        check("rst_ready",   bus.instr_ready, 1);
        check("rst_busy",    bus.busy,        0);
        check("rst_err",     bus.err,         0);
        check("rst_commit",  bus.commit,      0);
        check("rst_outs",    {bus.mul_start, bus.fpu_start, bus.mem_req, bus.mem_we, bus.fpu_op}, 0);
        check("rst_retired", bus.retired_cnt, 0);
        check("rst_stall",   bus.stall_cnt,   0);
    endtask

    // Issues one instruction at an IDLE negedge. lat = wait cycles until done
    // (1..TIMEOUT); lat > TIMEOUT means the resource never answers.
    task automatic do_instr(input logic [31:0] w, input int lat, input logic br);
        logic [2:0] cls;
        logic [1:0] f;
        bit is_mul, is_fpu, is_mem, exp_wb, exp_redir;
        int waited;
        cls    = w[31:29];
        f      = w[28:27];
        is_mul = (cls == 3'd0) && (f == 2'd3);
        is_fpu = (cls == 3'd5);
        is_mem = (cls == 3'd1) && (f <= 2'd1);
        case (cls)
            3'd0:       exp_wb = (f != 2'd3);
            3'd1:       exp_wb = (f != 2'd1);
            3'd4, 3'd6, 3'd7: exp_wb = 1'b1;
            default:    exp_wb = 1'b0;
        endcase
        exp_redir = (cls == 3'd3) || (cls == 3'd2 && br);

        check("idle_ready",   bus.instr_ready, 1);
        check("idle_retired", bus.retired_cnt, exp_ret);
        check("idle_stall",   bus.stall_cnt,   exp_stall);

        bus.instr_valid = 1'b1;
        bus.instr       = w;
        bus.br_taken    = br;
        bus.mul_done    = 1'($urandom_range(0, 1));
        bus.fpu_done    = 1'($urandom_range(0, 1));
        bus.mem_ack     = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.instr_valid = 1'($urandom_range(0, 1));
        bus.instr       = $urandom;
        check("busy_ready", bus.instr_ready, 0);
        check("busy_flag",  bus.busy,        1);

        if (!(is_mul || is_fpu || is_mem)) begin
            bus.mul_done = 1'($urandom_range(0, 1));
            bus.fpu_done = 1'($urandom_range(0, 1));
            bus.mem_ack  = 1'($urandom_range(0, 1));
            check("exec_nocommit", bus.commit, 0);
            @(negedge clk);
            bus.br_taken = ~br;
        end else begin
            waited = 0;
            for (int k = 1; k <= TIMEOUT; k++) begin
                check("wait_commit",  bus.commit,    0);
                check("wait_mulstart", bus.mul_start, is_mul && k == 1);
                check("wait_fpustart", bus.fpu_start, is_fpu && k == 1);
                check("wait_memreq",  bus.mem_req,   is_mem);
                check("wait_memwe",   bus.mem_we,    is_mem && f == 2'd1);
                if (is_fpu) check("wait_fpuop", bus.fpu_op, f);
                bus.mul_done = is_mul ? (k == lat) : 1'($urandom_range(0, 1));
                bus.fpu_done = is_fpu ? (k == lat) : 1'($urandom_range(0, 1));
                bus.mem_ack  = is_mem ? (k == lat) : 1'($urandom_range(0, 1));
                waited = k;
                @(negedge clk);
                if (k == lat) break;
            end
            exp_stall = sat_add(exp_stall, waited);
            bus.mul_done = 1'b0;
            bus.fpu_done = 1'b0;
            bus.mem_ack  = 1'b0;
            if (lat > TIMEOUT) begin
                for (int e = 0; e < 2; e++) begin
                    check("to_err",    bus.err,         1);
                    check("to_ready",  bus.instr_ready, 0);
                    check("to_commit", bus.commit,      0);
                    check("to_starts", {bus.mul_start, bus.fpu_start, bus.mem_req}, 0);
                    check("to_stall",  bus.stall_cnt,   exp_stall);
                    bus.instr_valid = 1'b1;
                    @(negedge clk);
                end
                do_reset();
                return;
            end
        end

        check("c_commit",   bus.commit,   1);
        check("c_wb_en",    bus.wb_en,    exp_wb);
        check("c_redirect", bus.redirect, exp_redir);
        exp_ret = sat_add(exp_ret, 1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check("post_commit", bus.commit, 0);
    endtask

    // Stack store abandoned by a reset in its second wait cycle.
    task automatic do_mem_abort();
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h2800_0000;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("ab_memreq_before", bus.mem_req, 1);
        rst = 1'b1;
        #1;
        check("ab_memreq",  bus.mem_req,     0);
        check("ab_busy",    bus.busy,        0);
        check("ab_retired", bus.retired_cnt, 0);
        check("ab_stall",   bus.stall_cnt,   0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        exp_ret   = 0;
        exp_stall = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            check("ab_nocommit", bus.commit,  0);
            check("ab_idle",     bus.busy,    0);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        return w;
    endfunction

    initial begin
        logic [31:0] w;
        int lat;
        idle_inputs();
        do_reset();

        do_instr(32'h0000_0000, 0, 1'b0);              // add
        do_instr(32'h1800_0000, 3, 1'b0);              // mul, done on 3rd wait cycle
        check("mul_stall3", bus.stall_cnt, 3);
        do_instr(32'h2800_0000, 2, 1'b0);              // sw
        do_instr(32'h2000_0000, 2, 1'b0);              // lw
        do_instr(32'h4000_0000, 0, 1'b1);              // beq taken
        do_instr(32'h4000_0000, 0, 1'b0);              // beq not taken
        do_instr(32'h6000_0000, 0, 1'b0);              // jump
        do_instr(32'hB000_0000, TIMEOUT + 1, 1'b0);    // float, never done
        do_instr(32'hB000_0000, TIMEOUT, 1'b0);        // float, done on last cycle
        check("fpu_last_noerr", bus.err, 0);
        do_mem_abort();

        for (int i = 0; i < CMAX + 4; i++) do_instr(32'hC000_1234, 0, 1'b0);
        check("ret_saturated", bus.retired_cnt, CMAX);

        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (i % 23 == 22) do_reset();
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                check("gap_commit", bus.commit, 0);
            end
            w   = rand_instr();
            lat = ($urandom_range(0, 11) == 0) ? TIMEOUT + 1 : int'($urandom_range(1, TIMEOUT));
            do_instr(w, lat, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
